// File: rtl/mini_mips_soc.sv
// mini_mips_soc: single-cycle MIPS32 subset core, word ROM, byte-banked RAM.
// Define UNALIGNED_LS_EN to add LWL/LWR/SWL/SWR; otherwise they act as NOPs.

module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  // write port; r0 is pinned to zero so probes of it always see 0
  always_ff @(posedge clk) begin
    regs[0] <= '0;
    if (we && waddr != 5'd0)
      regs[waddr] <= wdata;
  end

  // asynchronous read ports with r0 hardwired
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
  end
endmodule

module inst_rom #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [31:0]              addr,
  output logic [31:0]              inst
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] inst_mem [0:DEPTH-1];
  logic        unused_addr;

  // boot load port; tied off in the SoC, contents come from preload
  always_ff @(posedge clk) begin
    if (load_we)
      inst_mem[load_addr] <= load_data;
  end

  // combinational fetch by word index
  always_comb begin
    unused_addr = ^{addr[31:AW+2], addr[1:0]};
    inst        = inst_mem[addr[AW+1:2]];
  end
endmodule

module data_ram #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    bank0 [0:DEPTH-1];
  logic [7:0]    bank1 [0:DEPTH-1];
  logic [7:0]    bank2 [0:DEPTH-1];
  logic [7:0]    bank3 [0:DEPTH-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  // word index; upper and byte-offset bits are not part of it
  always_comb begin
    idx         = addr[AW+1:2];
    unused_addr = ^{addr[31:AW+2], addr[1:0]};
    rdata       = {bank3[idx], bank2[idx],
                   bank1[idx], bank0[idx]};
  end

  // byte-enabled write; bank3 holds the big-endian byte 0
  always_ff @(posedge clk) begin
    if (be[3]) bank3[idx] <= wdata[31:24];
    if (be[2]) bank2[idx] <= wdata[23:16];
    if (be[1]) bank1[idx] <= wdata[15:8];
    if (be[0]) bank0[idx] <= wdata[7:0];
  end
endmodule

module openmips (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata
);
  logic [31:0] pc_q, pc_d;
  logic [5:0]  op, funct;
  logic [4:0]  rs_a, rt_a, rd_a;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v, simm, zimm, ea;
  logic [4:0]  lsh, rsh;
  logic [31:0] byte_w;
  logic [15:0] half_v;
  logic        wb_en;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        unused_sa;

  regfile regfile1 (
    .clk    (clk),
    .we     (wb_en & rst),
    .waddr  (wb_a),
    .wdata  (wb_d),
    .raddr1 (rs_a),
    .raddr2 (rt_a),
    .rdata1 (rs_v),
    .rdata2 (rt_v)
  );

  // next sequential PC; there is no control flow
  always_comb begin
    pc_d = pc_q + 32'd4;
  end

  // PC register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  // decode, execute and memory access in one cycle
  always_comb begin
    op        = inst[31:26];
    rs_a      = inst[25:21];
    rt_a      = inst[20:16];
    rd_a      = inst[15:11];
    funct     = inst[5:0];
    imm       = inst[15:0];
    unused_sa = ^inst[10:6];
    simm      = {{16{imm[15]}}, imm};
    zimm      = {16'h0, imm};
    ea        = rs_v + simm;
    lsh       = {ea[1:0], 3'b000};
    rsh       = {~ea[1:0], 3'b000};
    byte_w    = mem_rdata >> rsh;
    half_v    = ea[1] ? mem_rdata[15:0]
                      : mem_rdata[31:16];
    wb_en     = 1'b0;
    wb_a      = rt_a;
    wb_d      = '0;
    be        = '0;
    wd        = '0;
    unique case (op)
      6'h0D: begin
        wb_en = 1'b1;
        wb_d  = rs_v | zimm;
      end
      6'h09: begin
        wb_en = 1'b1;
        wb_d  = rs_v + simm;
      end
      6'h0F: begin
        wb_en = 1'b1;
        wb_d  = {imm, 16'h0};
      end
      6'h00: begin
        wb_a = rd_a;
        if (funct == 6'h25) begin
          wb_en = 1'b1;
          wb_d  = rs_v | rt_v;
        end else if (funct == 6'h21) begin
          wb_en = 1'b1;
          wb_d  = rs_v + rt_v;
        end
      end
      6'h20: begin
        wb_en = 1'b1;
        wb_d  = {{24{byte_w[7]}}, byte_w[7:0]};
      end
      6'h24: begin
        wb_en = 1'b1;
        wb_d  = {24'h0, byte_w[7:0]};
      end
      6'h21: begin
        wb_en = 1'b1;
        wb_d  = {{16{half_v[15]}}, half_v};
      end
      6'h25: begin
        wb_en = 1'b1;
        wb_d  = {16'h0, half_v};
      end
      6'h23: begin
        wb_en = 1'b1;
        wb_d  = mem_rdata;
      end
      6'h28: begin
        be = 4'b1000 >> ea[1:0];
        wd = {4{rt_v[7:0]}};
      end
      6'h29: begin
        be = ea[1] ? 4'b0011 : 4'b1100;
        wd = {2{rt_v[15:0]}};
      end
      6'h2B: begin
        be = 4'b1111;
        wd = rt_v;
      end
`ifdef UNALIGNED_LS_EN
      6'h22: begin
        wb_en = 1'b1;
        wb_d  = (mem_rdata << lsh)
              | (rt_v & ((32'h1 << lsh) - 32'h1));
      end
      6'h26: begin
        wb_en = 1'b1;
        wb_d  = (rt_v & ~(32'hFFFF_FFFF >> rsh))
              | (mem_rdata >> rsh);
      end
      6'h2A: begin
        be = 4'b1111 >> ea[1:0];
        wd = rt_v >> lsh;
      end
      6'h2E: begin
        be = 4'b1111 << (~ea[1:0]);
        wd = rt_v << rsh;
      end
`endif
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  // bus outputs; stores are dropped while in reset
  always_comb begin
    pc        = pc_q;
    mem_addr  = ea;
    mem_be    = rst ? be : 4'b0000;
    mem_wdata = wd;
  end
endmodule

module mini_mips_soc #(
  parameter int IROM_DEPTH = 32,
  parameter int DRAM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dbg_pc
);
  logic [31:0] pc, inst, mem_addr;
  logic [31:0] mem_rdata, mem_wdata;
  logic [3:0]  mem_be;

  openmips openmips0 (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .pc        (pc),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata)
  );

  inst_rom #(.DEPTH(IROM_DEPTH)) inst_rom0 (
    .clk       (clk),
    .load_we   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .addr      (pc),
    .inst      (inst)
  );

  data_ram #(.DEPTH(DRAM_DEPTH)) data_ram0 (
    .clk   (clk),
    .addr  (mem_addr),
    .be    (mem_be),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign dbg_pc = pc;
endmodule

// File: tb/tb_mini_mips_soc.sv
// tb_mini_mips_soc: preloads a program, scoreboards retire-time
// register and memory results, checks reset behaviour and PC sequence.

module tb_mini_mips_soc;
  logic        clk;
  logic        rst;
  logic [31:0] dbg_pc;

  int n_chk;
  int n_err;

  typedef struct {
    int          cyc;
    bit          is_mem;
    int          idx;
    logic [31:0] mask;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];

  mini_mips_soc dut (
    .clk    (clk),
    .rst    (rst),
    .dbg_pc (dbg_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_reg(input int n);
    return dut.openmips0.regfile1.regs[n];
  endfunction

  function automatic logic [31:0] rd_mem(input int w);
    return {dut.data_ram0.bank3[w], dut.data_ram0.bank2[w],
            dut.data_ram0.bank1[w], dut.data_ram0.bank0[w]};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] rt3(input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [4:0] rd,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic push(input int cyc, input bit is_mem,
                      input int idx, input logic [31:0] mask,
                      input logic [31:0] exp, input string tag);
    sb_t e;
    e.cyc = cyc; e.is_mem = is_mem; e.idx = idx;
    e.mask = mask; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain(input int cyc);
    sb_t e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      act = e.is_mem ? rd_mem(e.idx) : rd_reg(e.idx);
      chk(e.tag, act & e.mask, e.exp & e.mask);
    end
  endtask

  initial begin
    logic [31:0] m;
    bit ul;
    n_chk = 0;
    n_err = 0;
`ifdef UNALIGNED_LS_EN
    ul = 1'b1;
`else
    ul = 1'b0;
`endif
    m = 32'hFFFF_FFFF;
    rst = 1'b0;

    for (int i = 0; i < 32; i++)
      dut.inst_rom0.inst_mem[i] = 32'h0;
    dut.inst_rom0.inst_mem[0]  = it(6'h0D, 0, 3, 16'hEEFF);
    dut.inst_rom0.inst_mem[1]  = it(6'h28, 0, 3, 16'd3);
    dut.inst_rom0.inst_mem[2]  = it(6'h0D, 0, 3, 16'h00EE);
    dut.inst_rom0.inst_mem[3]  = it(6'h28, 0, 3, 16'd2);
    dut.inst_rom0.inst_mem[4]  = it(6'h20, 0, 1, 16'd3);
    dut.inst_rom0.inst_mem[5]  = it(6'h24, 0, 1, 16'd2);
    dut.inst_rom0.inst_mem[6]  = it(6'h0D, 0, 3, 16'hAABB);
    dut.inst_rom0.inst_mem[7]  = it(6'h29, 0, 3, 16'd4);
    dut.inst_rom0.inst_mem[8]  = it(6'h25, 0, 1, 16'd4);
    dut.inst_rom0.inst_mem[9]  = it(6'h21, 0, 1, 16'd4);
    dut.inst_rom0.inst_mem[10] = it(6'h0F, 0, 3, 16'h4455);
    dut.inst_rom0.inst_mem[11] = it(6'h0D, 3, 3, 16'h6677);
    dut.inst_rom0.inst_mem[12] = it(6'h2B, 0, 3, 16'd8);
    dut.inst_rom0.inst_mem[13] = it(6'h23, 0, 1, 16'd8);
    dut.inst_rom0.inst_mem[14] = it(6'h0D, 0, 3, 16'h9977);
    dut.inst_rom0.inst_mem[15] = it(6'h29, 0, 3, 16'd6);
    dut.inst_rom0.inst_mem[16] = it(6'h0D, 0, 3, 16'hBB88);
    dut.inst_rom0.inst_mem[17] = it(6'h29, 0, 3, 16'd4);
    dut.inst_rom0.inst_mem[18] = it(6'h23, 0, 1, 16'd4);
    dut.inst_rom0.inst_mem[19] = it(6'h22, 0, 1, 16'd5);
    dut.inst_rom0.inst_mem[20] = it(6'h23, 0, 1, 16'd4);
    dut.inst_rom0.inst_mem[21] = it(6'h26, 0, 1, 16'd8);
    dut.inst_rom0.inst_mem[22] = it(6'h2E, 0, 1, 16'd8);
    dut.inst_rom0.inst_mem[23] = it(6'h2A, 0, 1, 16'd9);
    dut.inst_rom0.inst_mem[24] = it(6'h0D, 0, 0, 16'h1234);
    dut.inst_rom0.inst_mem[25] = it(6'h09, 0, 4, 16'hFFFF);
    dut.inst_rom0.inst_mem[26] = rt3(4, 3, 5, 6'h21);
    dut.inst_rom0.inst_mem[27] = it(6'h09, 4, 7, 16'd2);
    dut.inst_rom0.inst_mem[28] = rt3(3, 7, 6, 6'h25);
    dut.inst_rom0.inst_mem[29] = it(6'h2B, 0, 4, 16'd12);

    dut.openmips0.regfile1.regs[1] = 32'h1234_5678;
    dut.openmips0.regfile1.regs[3] = 32'h5A5A_5A5A;
    dut.data_ram0.bank3[3] = 8'hCA;
    dut.data_ram0.bank2[3] = 8'hFE;
    dut.data_ram0.bank1[3] = 8'hF0;
    dut.data_ram0.bank0[3] = 8'h0D;

    push(3,  1, 0, 32'h0000_FFFF, 32'h0000_EEFF, "sb_w0");
    push(4,  0, 1, m, 32'hFFFF_FFFF, "lb");
    push(5,  0, 1, m, 32'h0000_00EE, "lbu");
    push(7,  1, 1, 32'hFFFF_0000, 32'hAABB_0000, "sh_w1");
    push(8,  0, 1, m, 32'h0000_AABB, "lhu");
    push(9,  0, 1, m, 32'hFFFF_AABB, "lh");
    push(11, 0, 3, m, 32'h4455_6677, "lui_ori");
    push(12, 1, 2, m, 32'h4455_6677, "sw_w2");
    push(13, 0, 1, m, 32'h4455_6677, "lw");
    push(17, 1, 1, m, 32'hBB88_9977, "sh_lo_w1");
    push(18, 0, 1, m, 32'hBB88_9977, "lw_w1");
    push(19, 0, 1, m, ul ? 32'h8899_7777
                         : 32'hBB88_9977, "lwl");
    push(21, 0, 1, m, ul ? 32'hBB88_9944
                         : 32'hBB88_9977, "lwr");
    push(22, 1, 2, m, 32'h4455_6677, "swr");
    push(23, 1, 2, m, ul ? 32'h44BB_8899
                         : 32'h4455_6677, "swl");
    push(24, 0, 0, m, 32'h0, "r0_zero");
    push(25, 0, 4, m, 32'hFFFF_FFFF, "addiu_neg");
    push(26, 0, 5, m, 32'h0000_BB87, "addu_wrap");
    push(27, 0, 7, m, 32'h0000_0001, "addiu_wrap");
    push(28, 0, 6, m, 32'h0000_BB89, "or");

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", dbg_pc, 32'h0);
    chk("rst_r1", rd_reg(1), 32'h1234_5678);
    chk("rst_r3", rd_reg(3), 32'h5A5A_5A5A);
    chk("rst_w3", rd_mem(3), 32'hCAFE_F00D);

    rst = 1'b1;
    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pc_seq", dbg_pc, 32'(4 * (i + 1)));
      drain(i);
    end
    chk("sb_empty", 32'(sb.size()), 32'h0);

    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_pc", dbg_pc, 32'h0);
    chk("mid_rst_sw", rd_mem(3), 32'hCAFE_F00D);
    chk("mid_rst_r4", rd_reg(4), 32'hFFFF_FFFF);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_pc", dbg_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
